// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, ROM addressing and the IF/ID
// pipeline register. Handles stall (LE low), branch redirect with a single
// bubble, and flush of the slot entering IF/ID.
module fetch_stage #(
  parameter int                   ADDR_W  = 8,
  parameter int                   INSTR_W = 32,
  parameter int                   PC_INC  = 4,
  parameter logic [INSTR_W-1:0]   NOP     = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               R,
  input  logic               LE,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               flush,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_link,
  output logic               id_valid,
  output logic [15:0]        fetch_cnt
);

  // PC step truncated to the address width so all PC arithmetic wraps.
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  idpc_q, idpc_d;
  logic [ADDR_W-1:0]  link_q, link_d;
  logic               valid_q, valid_d;
  logic [15:0]        cnt_q, cnt_d;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      sat_inc = val;
    end else begin
      sat_inc = val + 16'd1;
    end
  endfunction

  // Stall state for the current state: RUN drops into HOLD, BOOT/HOLD stay put.
  function automatic state_t stall_state(input state_t cur);
    case (cur)
      S_BOOT:  stall_state = S_BOOT;
      S_RUN:   stall_state = S_HOLD;
      S_HOLD:  stall_state = S_HOLD;
      default: stall_state = S_BOOT;
    endcase
  endfunction

  // Next-state and next-register computation; branch beats stall beats flush.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    link_d  = link_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (br_taken) begin
      // Redirect: bubble enters IF/ID, id_pc/id_link keep their last values.
      pc_d    = br_target;
      instr_d = NOP;
      valid_d = 1'b0;
      state_d = S_RUN;
    end else if (!LE) begin
      // Stall: every register holds, only the FSM records the stall.
      state_d = stall_state(state_q);
    end else if (flush) begin
      // Squash the fetched word but keep the PC moving.
      pc_d    = pc_q + PC_STEP;
      instr_d = NOP;
      valid_d = 1'b0;
      state_d = S_RUN;
    end else begin
      // Normal advance: ROM word at the current PC moves into IF/ID.
      pc_d    = pc_q + PC_STEP;
      instr_d = rom_data;
      idpc_d  = pc_q;
      link_d  = pc_q + PC_STEP;
      valid_d = 1'b1;
      cnt_d   = sat_inc(cnt_q);
      state_d = S_RUN;
    end
  end

  // State and pipeline registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= S_BOOT;
      pc_q    <= {ADDR_W{1'b0}};
      instr_q <= NOP;
      idpc_q  <= {ADDR_W{1'b0}};
      link_q  <= {ADDR_W{1'b0}};
      valid_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      link_q  <= link_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs come straight from flops, so rom_addr cannot glitch mid-cycle.
  assign rom_addr  = pc_q;
  assign id_instr  = instr_q;
  assign id_pc     = idpc_q;
  assign id_link   = link_q;
  assign id_valid  = valid_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed vector table, hand-written
// asynchronous-reset sequence, and randomized traffic against a reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        R;
  logic        LE;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        flush;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic [7:0]  id_link;
  logic        id_valid;
  logic [15:0] fetch_cnt;

  logic [31:0] rom_mem [0:255];

  int errors = 0;
  int checks = 0;

  // Reference model state (architectural view only).
  logic [7:0]  m_pc, m_idpc, m_link;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [15:0] m_cnt;

  typedef struct {
    logic        le;
    logic        br;
    logic [7:0]  tgt;
    logic        fl;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [7:0]  idpc;
    logic [7:0]  link;
    logic        valid;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  fetch_stage dut (
    .clk       (clk),
    .R         (R),
    .LE        (LE),
    .br_taken  (br_taken),
    .br_target (br_target),
    .flush     (flush),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_link   (id_link),
    .id_valid  (id_valid),
    .fetch_cnt (fetch_cnt)
  );

  function automatic vec_t mk(input logic le, input logic br, input logic [7:0] tgt,
                              input logic fl, input logic [7:0] pc, input logic [31:0] instr,
                              input logic [7:0] idpc, input logic [7:0] link,
                              input logic valid, input logic [15:0] cnt);
    vec_t v;
    v.le = le; v.br = br; v.tgt = tgt; v.fl = fl;
    v.pc = pc; v.instr = instr; v.idpc = idpc; v.link = link;
    v.valid = valid; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] pc, input logic [31:0] instr,
                               input logic [7:0] idpc, input logic [7:0] link,
                               input logic valid, input logic [15:0] cnt);
    chk({tag, ".rom_addr"},  {24'd0, rom_addr},  {24'd0, pc});
    chk({tag, ".id_instr"},  id_instr,           instr);
    chk({tag, ".id_pc"},     {24'd0, id_pc},     {24'd0, idpc});
    chk({tag, ".id_link"},   {24'd0, id_link},   {24'd0, link});
    chk({tag, ".id_valid"},  {31'd0, id_valid},  {31'd0, valid});
    chk({tag, ".fetch_cnt"}, {16'd0, fetch_cnt}, {16'd0, cnt});
  endtask

  task automatic model_reset();
    m_pc = 8'd0; m_idpc = 8'd0; m_link = 8'd0;
    m_instr = 32'd0; m_valid = 1'b0; m_cnt = 16'd0;
  endtask

  // One clock edge of the fetch rules, written directly from the behaviour list.
  task automatic model_edge(input logic le, input logic br, input logic [7:0] tgt, input logic fl);
    if (br) begin
      m_pc = tgt; m_instr = 32'd0; m_valid = 1'b0;
    end else if (!le) begin
      m_pc = m_pc;
    end else if (fl) begin
      m_pc = m_pc + 8'd4; m_instr = 32'd0; m_valid = 1'b0;
    end else begin
      m_instr = rom_mem[m_pc];
      m_idpc  = m_pc;
      m_link  = m_pc + 8'd4;
      m_pc    = m_pc + 8'd4;
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic drive(input logic le, input logic br, input logic [7:0] tgt, input logic fl);
    LE = le; br_taken = br; br_target = tgt; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    R = 1'b1; LE = 1'b0; br_taken = 1'b0; br_target = 8'd0; flush = 1'b0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 32'(i / 4 + 1);

    //        le   br   tgt    fl   pc     instr   idpc   link   v    cnt
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h00, 8'h00, 8'h00, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 32'h01, 8'h00, 8'h04, 1'b1, 16'd1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h08, 32'h02, 8'h04, 8'h08, 1'b1, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h0C, 32'h03, 8'h08, 8'h0C, 1'b1, 16'd3));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h0C, 32'h03, 8'h08, 8'h0C, 1'b1, 16'd3));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h0C, 32'h03, 8'h08, 8'h0C, 1'b1, 16'd3));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h0C, 32'h03, 8'h08, 8'h0C, 1'b1, 16'd3));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 32'h04, 8'h0C, 8'h10, 1'b1, 16'd4));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h14, 32'h00, 8'h0C, 8'h10, 1'b0, 16'd4));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h18, 32'h06, 8'h14, 8'h18, 1'b1, 16'd5));
    vecs.push_back(mk(1'b0, 1'b1, 8'h40, 1'b1, 8'h40, 32'h00, 8'h14, 8'h18, 1'b0, 16'd5));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h44, 32'h11, 8'h40, 8'h44, 1'b1, 16'd6));
    vecs.push_back(mk(1'b1, 1'b1, 8'hFC, 1'b0, 8'hFC, 32'h00, 8'h40, 8'h44, 1'b0, 16'd6));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 32'h40, 8'hFC, 8'h00, 1'b1, 16'd7));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 32'h01, 8'h00, 8'h04, 1'b1, 16'd8));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 32'h01, 8'h00, 8'h04, 1'b1, 16'd8));
    vecs.push_back(mk(1'b0, 1'b1, 8'h41, 1'b0, 8'h41, 32'h00, 8'h00, 8'h04, 1'b0, 16'd8));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h45, 32'h11, 8'h41, 8'h45, 1'b1, 16'd9));

    // Reset state while R is held and after release.
    #3;
    check_outputs("reset_held", 8'h00, 32'h0, 8'h00, 8'h00, 1'b0, 16'd0);
    #9;
    R = 1'b0;
    #1;
    check_outputs("reset_rel", 8'h00, 32'h0, 8'h00, 8'h00, 1'b0, 16'd0);

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].le, vecs[i].br, vecs[i].tgt, vecs[i].fl);
      check_outputs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].idpc,
                    vecs[i].link, vecs[i].valid, vecs[i].cnt);
    end

    // Asynchronous reset between edges while stalled, then BOOT fetch of ROM[0].
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    R = 1'b1;
    #1;
    check_outputs("async_rst", 8'h00, 32'h0, 8'h00, 8'h00, 1'b0, 16'd0);
    LE = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_over_edge", 8'h00, 32'h0, 8'h00, 8'h00, 1'b0, 16'd0);
    #2;
    R = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_outputs("boot_stall", 8'h00, 32'h0, 8'h00, 8'h00, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check_outputs("boot_fetch", 8'h04, 32'h1, 8'h00, 8'h04, 1'b1, 16'd1);

    // Randomized traffic against the reference model, fresh ROM contents.
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    #2;
    R = 1'b1;
    #2;
    R = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       le, br, fl;
      logic [7:0] tgt;
      le  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      tgt = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) tgt = {tgt[7:2], 2'b00};
      drive(le, br, tgt, fl);
      model_edge(le, br, tgt, fl);
      check_outputs($sformatf("rand%0d", i), m_pc, m_instr, m_idpc, m_link, m_valid, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
